gate_tt_sequencer: RTL and testbench
====================================

Name: gate_tt_sequencer

Overview:
Controller that exhaustively exercises a small combinational gate (e.g. or_gate) in-circuit. It steps the gate's inputs through every vector 0..2^N_IN-1 and holds each for a programmable settle time. It samples the gate output into a captured truth table and compares that table against an expected table. It sits between a host/test controller and the gate instance, and owns the gate's input pins.

Parameters:
N_IN, 2, number of gate inputs (>=1)
SETTLE, 1, extra hold cycles per vector before sampling (>=0); per-vector period = SETTLE+1 cycles
TT_W, 2**N_IN, derived localparam, truth-table width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a sweep; sampled only in IDLE
abort  in  1  cancel a running sweep
expected  in  TT_W  expected truth table, bit k = gate output for input vector k; latched at start
gate_out  in  1  output of the gate under control
gate_in  out  N_IN  drives gate inputs; gate_in[N_IN-1] = MSB of vector (for or_gate: a=gate_in[1], b=gate_in[0])
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at sweep completion
pass  out  1  captured table == latched expected (valid when done is high; held afterwards)
tt  out  TT_W  captured truth table
err_idx  out  N_IN  lowest mismatching vector index; 0 when pass=1

Behaviour:
- Reset (rst high at an edge): state=IDLE; gate_in=0, busy=0, done=0, pass=0, tt=0, err_idx=0; internal counters=0. Applies mid-sweep too; no done pulse is produced.
- States: IDLE, RUN. All outputs are registered.
- IDLE, start=1, abort=0 at edge E0:
  - latch expected into exp_q
  - tt<=0, pass<=0, err_idx<=0
  - vec<=0, gate_in<=0, settle_cnt<=0
  - busy<=1; go to RUN
- RUN:
  - Each vector k is driven on gate_in for exactly SETTLE+1 cycles.
  - While settle_cnt<SETTLE: settle_cnt++.
  - When settle_cnt==SETTLE: tt[k]<=gate_out, settle_cnt<=0, vec<=k+1, gate_in<=k+1.
  - Sample edges: E0+(SETTLE+1)*(k+1).
- Completion: at the sample edge of k=TT_W-1 (E0+(SETTLE+1)*TT_W):
  - tt[TT_W-1] captured
  - done<=1 for one cycle
  - busy<=0, gate_in<=0, state<=IDLE
  - pass<=(final tt==exp_q); err_idx<=lowest index where final tt and exp_q differ, else 0
  - Defaults: done is high during the 9th cycle after E0 (sample edge E0+8).
- vec counter width is N_IN+1 so the terminal vector is detected without wrap ambiguity. gate_in = vec[N_IN-1:0].
- start while busy: ignored. expected changes while busy: ignored (exp_q used).
- abort=1 in RUN at an edge: busy<=0, gate_in<=0, state<=IDLE, pass<=0, no done. tt keeps the partially captured bits.
- abort in IDLE: no effect. start and abort both high in IDLE: abort wins, start ignored.
- start=1 during the done cycle (state already IDLE): accepted. A new sweep starts next edge, so back-to-back sweeps are possible, and done drops.
- tt, pass and err_idx hold their values until the next accepted start or rst.
- SETTLE=0: one cycle per vector; gate_in changes every cycle.

Test Plan:
1. OR gate, defaults, expected=4'b1110, 1-cycle start pulse
   -> busy=1; gate_in sequence 0,0,1,1,2,2,3,3 across 8 cycles
   -> done pulse on the following cycle; tt=4'b1110, pass=1, err_idx=0; busy=0, gate_in=0
2. OR gate, expected=4'b1000 (AND table)
   -> tt=4'b1110, pass=0, err_idx=1 at done
3. SETTLE=3, OR gate, expected=4'b1110
   -> each vector held 4 cycles; done at edge E0+16; pass=1
4. abort asserted 3 cycles after E0
   -> next edge: busy=0, gate_in=0, pass=0, no done pulse; tt bit0 captured=0, upper bits 0
   -> subsequent start runs a clean full sweep
5. start re-pulsed mid-sweep -> ignored, sweep timing unchanged
   start held high through the done cycle -> second sweep starts next edge with identical gate_in sequence; pass/tt cleared at acceptance
6. rst asserted mid-sweep (vector 2 driven) -> next edge: all outputs 0, state IDLE, no done; start afterwards behaves as scenario 1

Source files
------------

// File: rtl/gate_tt_sequencer_if.sv
// Host/gate-side bundle for gate_tt_sequencer: sweep control, the gate's pins,
// and the captured truth-table results.
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
);
  localparam int TT_W = 2 ** N_IN;

  logic            start;
  logic            abort;
  logic [TT_W-1:0] expected;
  logic            gate_out;
  logic [N_IN-1:0] gate_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [TT_W-1:0] tt;
  logic [N_IN-1:0] err_idx;

  modport master (
    output start, abort, expected, gate_out,
    input  gate_in, busy, done, pass, tt, err_idx
  );

  modport slave (
    input  start, abort, expected, gate_out,
    output gate_in, busy, done, pass, tt, err_idx
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Sweeps a small combinational gate through every input vector, holds each for
// SETTLE+1 cycles, captures its truth table and compares it with the expected one.
module gate_tt_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input logic             clk,
  input logic             rst,
  gate_tt_sequencer_if.slave bus
);
  localparam int TT_W  = 2 ** N_IN;
  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN:0]   vec_q, vec_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [N_IN-1:0] gate_in_q, gate_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic [N_IN-1:0] err_idx_q, err_idx_d;
  logic [TT_W-1:0] exp_q, exp_d;

  logic [N_IN:0]   vec_nxt;
  logic [TT_W-1:0] tt_smp;

  function automatic logic [N_IN-1:0] lowest_set(input logic [TT_W-1:0] v);
    lowest_set = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = i[N_IN-1:0];
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_cnt_d = settle_cnt_q;
    gate_in_d    = gate_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    tt_d         = tt_q;
    err_idx_d    = err_idx_q;
    exp_d        = exp_q;

    // The extra MSB of vec makes the last vector visible as a carry out.
    vec_nxt = vec_q + 1'b1;
    tt_smp  = tt_q;
    tt_smp[vec_q[N_IN-1:0]] = bus.gate_out;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          exp_d        = bus.expected;
          tt_d         = '0;
          pass_d       = 1'b0;
          err_idx_d    = '0;
          vec_d        = '0;
          gate_in_d    = '0;
          settle_cnt_d = '0;
          busy_d       = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          busy_d       = 1'b0;
          gate_in_d    = '0;
          pass_d       = 1'b0;
          vec_d        = '0;
          settle_cnt_d = '0;
          state_d      = IDLE;
        end else if (settle_cnt_q != SETTLE_C) begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end else begin
          tt_d         = tt_smp;
          settle_cnt_d = '0;
          if (vec_nxt[N_IN]) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            gate_in_d = '0;
            vec_d     = '0;
            pass_d    = (tt_smp == exp_q);
            err_idx_d = lowest_set(tt_smp ^ exp_q);
            state_d   = IDLE;
          end else begin
            vec_d     = vec_nxt;
            gate_in_d = vec_nxt[N_IN-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_cnt_q <= '0;
      gate_in_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      tt_q         <= '0;
      err_idx_q    <= '0;
      exp_q        <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_cnt_q <= settle_cnt_d;
      gate_in_q    <= gate_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      tt_q         <= tt_d;
      err_idx_q    <= err_idx_d;
      exp_q        <= exp_d;
    end
  end

  assign bus.gate_in = gate_in_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.tt      = tt_q;
  assign bus.err_idx = err_idx_q;
endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Scoreboard bench for gate_tt_sequencer: three instances (SETTLE 1, 3, 0), each
// driving a table-defined gate; per-cycle expectations queued, monitor compares.
module tb_gate_tt_sequencer;
  localparam int N_IN = 2;
  localparam int TT_W = 4;
  localparam int ND   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s   [ND];
  logic       start_s [ND];
  logic       abort_s [ND];
  logic [3:0] exp_s   [ND];
  logic [3:0] gtab    [ND];

  logic [1:0] gi_o    [ND];
  logic       busy_o  [ND];
  logic       done_o  [ND];
  logic       pass_o  [ND];
  logic [3:0] tt_o    [ND];
  logic [1:0] err_o   [ND];

  gate_tt_sequencer_if #(.N_IN(N_IN)) if0 ();
  gate_tt_sequencer_if #(.N_IN(N_IN)) if1 ();
  gate_tt_sequencer_if #(.N_IN(N_IN)) if2 ();

  assign if0.start = start_s[0];  assign if0.abort = abort_s[0];  assign if0.expected = exp_s[0];
  assign if1.start = start_s[1];  assign if1.abort = abort_s[1];  assign if1.expected = exp_s[1];
  assign if2.start = start_s[2];  assign if2.abort = abort_s[2];  assign if2.expected = exp_s[2];
  assign if0.gate_out = gtab[0][if0.gate_in];
  assign if1.gate_out = gtab[1][if1.gate_in];
  assign if2.gate_out = gtab[2][if2.gate_in];

  assign gi_o[0] = if0.gate_in; assign busy_o[0] = if0.busy; assign done_o[0] = if0.done;
  assign pass_o[0] = if0.pass;  assign tt_o[0] = if0.tt;     assign err_o[0] = if0.err_idx;
  assign gi_o[1] = if1.gate_in; assign busy_o[1] = if1.busy; assign done_o[1] = if1.done;
  assign pass_o[1] = if1.pass;  assign tt_o[1] = if1.tt;     assign err_o[1] = if1.err_idx;
  assign gi_o[2] = if2.gate_in; assign busy_o[2] = if2.busy; assign done_o[2] = if2.done;
  assign pass_o[2] = if2.pass;  assign tt_o[2] = if2.tt;     assign err_o[2] = if2.err_idx;

  gate_tt_sequencer #(.N_IN(N_IN), .SETTLE(1)) u_dut0 (.clk(clk), .rst(rst_s[0]), .bus(if0.slave));
  gate_tt_sequencer #(.N_IN(N_IN), .SETTLE(3)) u_dut1 (.clk(clk), .rst(rst_s[1]), .bus(if1.slave));
  gate_tt_sequencer #(.N_IN(N_IN), .SETTLE(0)) u_dut2 (.clk(clk), .rst(rst_s[2]), .bus(if2.slave));

  typedef struct packed {
    logic [1:0] gi;
    logic       busy;
    logic       done;
    logic       chk;
    logic [3:0] tt;
    logic       pass;
    logic [1:0] err;
  } exp_t;

  exp_t       tq [ND][$];
  logic [3:0] last_tt   [ND];
  logic       last_pass [ND];
  logic [1:0] last_err  [ND];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int settle_of(input int d);
    case (d)
      0:       settle_of = 1;
      1:       settle_of = 3;
      default: settle_of = 0;
    endcase
  endfunction

  function automatic logic [1:0] first_diff(input logic [3:0] a, input logic [3:0] b);
    bit found;
    found = 1'b0;
    first_diff = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!found && a[k] != b[k]) begin
        first_diff = 2'(k);
        found = 1'b1;
      end
    end
  endfunction

  function automatic exp_t mk(input logic [1:0] gi, input logic busy, input logic done,
                              input logic chk, input logic [3:0] tt, input logic pass,
                              input logic [1:0] err);
    mk.gi = gi; mk.busy = busy; mk.done = done; mk.chk = chk;
    mk.tt = tt; mk.pass = pass; mk.err = err;
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t actual=%0h required=%0h", nm, d, $time, act, req);
    end
  endtask

  // Monitor: one expectation per cycle while a sweep is scheduled, otherwise idle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    for (int d = 0; d < ND; d++) begin
      if (tq[d].size() > 0) begin
        e = tq[d].pop_front();
        check("gate_in", d, 32'(gi_o[d]), 32'(e.gi));
        check("busy",    d, 32'(busy_o[d]), 32'(e.busy));
        check("done",    d, 32'(done_o[d]), 32'(e.done));
        if (e.chk) begin
          check("tt",      d, 32'(tt_o[d]), 32'(e.tt));
          check("pass",    d, 32'(pass_o[d]), 32'(e.pass));
          check("err_idx", d, 32'(err_o[d]), 32'(e.err));
        end
      end else begin
        check("idle_busy", d, 32'(busy_o[d]), 32'd0);
        check("idle_done", d, 32'(done_o[d]), 32'd0);
      end
    end
  end

  task automatic reset_all(input int n);
    for (int d = 0; d < ND; d++) begin
      rst_s[d] = 1'b1;
      for (int i = 0; i < n; i++) tq[d].push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0));
      last_tt[d] = 4'd0; last_pass[d] = 1'b0; last_err[d] = 2'd0;
    end
    repeat (n) @(negedge clk);
    for (int d = 0; d < ND; d++) rst_s[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n, input logic st, input logic ab);
    for (int i = 0; i < n; i++) begin
      start_s[d] = st;
      abort_s[d] = ab;
      tq[d].push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, last_tt[d], last_pass[d], last_err[d]));
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
  endtask

  // One sweep from the reference rules: vector k occupies cycles [k*P, (k+1)*P),
  // results appear after edge N = P*TT_W unless abort/reset cuts it short.
  task automatic sweep(input int d, input logic [3:0] tab, input logic [3:0] expv,
                       input int abort_at, input int rst_at, input int repulse_at,
                       input bit hold, input bit wiggle);
    int p, n, stop, ncap;
    logic [3:0] mask;
    p = settle_of(d) + 1;
    n = p * TT_W;
    stop = n;
    if (abort_at > 0) stop = abort_at;
    else if (rst_at > 0) stop = rst_at;
    gtab[d] = tab;
    exp_s[d] = expv;
    tq[d].push_back(mk(2'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0));
    for (int t = 1; t < stop; t++) tq[d].push_back(mk(2'(t / p), 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0));
    if (abort_at > 0) begin
      ncap = (stop - 1) / p;
      mask = 4'd0;
      for (int k = 0; k < ncap; k++) mask[k] = 1'b1;
      last_tt[d] = tab & mask; last_pass[d] = 1'b0; last_err[d] = 2'd0;
      tq[d].push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, last_tt[d], 1'b0, 2'd0));
    end else if (rst_at > 0) begin
      last_tt[d] = 4'd0; last_pass[d] = 1'b0; last_err[d] = 2'd0;
      tq[d].push_back(mk(2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 2'd0));
    end else begin
      last_tt[d] = tab; last_pass[d] = (tab == expv); last_err[d] = first_diff(tab, expv);
      tq[d].push_back(mk(2'd0, 1'b0, 1'b1, 1'b1, last_tt[d], last_pass[d], last_err[d]));
    end
    for (int t = 0; t <= stop; t++) begin
      start_s[d] = (t == 0) || hold || (t == repulse_at);
      abort_s[d] = (abort_at > 0) && (t == abort_at);
      rst_s[d]   = (rst_at > 0) && (t == rst_at);
      if (wiggle && t > 0) exp_s[d] = 4'($urandom);
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    abort_s[d] = 1'b0;
    rst_s[d]   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, n, ab, rs, rp, gap;
    bit hd, wg;
    logic [3:0] tab, ev;
    for (int i = 0; i < ND; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; rst_s[i] = 1'b1;
      exp_s[i] = 4'd0; gtab[i] = 4'b1110;
    end
    reset_all(3);

    sweep(0, 4'b1110, 4'b1110, 0, 0, 0, 1'b0, 1'b0);
    idle(0, 1, 1'b0, 1'b0);
    sweep(0, 4'b1110, 4'b1000, 0, 0, 0, 1'b0, 1'b0);
    idle(0, 2, 1'b0, 1'b0);
    sweep(1, 4'b1110, 4'b1110, 0, 0, 0, 1'b0, 1'b0);
    idle(1, 1, 1'b0, 1'b0);
    sweep(0, 4'b1110, 4'b1110, 3, 0, 0, 1'b0, 1'b0);
    idle(0, 1, 1'b0, 1'b0);
    sweep(0, 4'b1110, 4'b1110, 0, 0, 0, 1'b0, 1'b0);
    sweep(0, 4'b1110, 4'b1110, 0, 0, 3, 1'b0, 1'b1);
    sweep(0, 4'b1110, 4'b1110, 0, 0, 0, 1'b1, 1'b0);
    sweep(0, 4'b1110, 4'b1000, 0, 0, 0, 1'b0, 1'b0);
    idle(0, 2, 1'b1, 1'b1);
    idle(0, 2, 1'b0, 1'b1);
    sweep(0, 4'b1110, 4'b1110, 0, 5, 0, 1'b0, 1'b0);
    idle(0, 1, 1'b0, 1'b0);
    sweep(0, 4'b1110, 4'b1110, 0, 0, 0, 1'b0, 1'b0);
    sweep(2, 4'b1110, 4'b1110, 0, 0, 0, 1'b0, 1'b0);
    sweep(2, 4'b0110, 4'b1110, 0, 0, 0, 1'b0, 1'b0);
    idle(2, 1, 1'b0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      d   = int'($urandom_range(0, ND - 1));
      p   = settle_of(d) + 1;
      n   = p * TT_W;
      tab = 4'($urandom);
      ev  = ($urandom_range(0, 1) == 0) ? tab : 4'($urandom);
      ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n)) : 0;
      rs  = (ab == 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, n)) : 0;
      rp  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n - 1)) : 0;
      hd  = ($urandom_range(0, 3) == 0);
      wg  = ($urandom_range(0, 1) == 0);
      sweep(d, tab, ev, ab, rs, rp, hd, wg);
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle(d, gap, 1'($urandom), 1'b1);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) check("drain", i, 32'(tq[i].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
